// File: rtl/lsu_align_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lsu_pkg
// Brief    : Shared types for the load/store alignment unit: access-size
//            encoding, FSM state enum and the byte-enable mask helper.
// Revision : 1.0 - initial release
// ============================================================================
package lsu_pkg;

  localparam logic [1:0] SZ_BYTE  = 2'b00;
  localparam logic [1:0] SZ_HALF  = 2'b01;
  localparam logic [1:0] SZ_WORD  = 2'b10;
  localparam logic [1:0] SZ_DWORD = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } lsu_state_t;

  // Contiguous run of (1 << size) lanes starting at lane ofs, sized for the
  // widest (8-lane) bus; narrower callers keep the low bits.
  function automatic logic [7:0] be_mask(input logic [1:0] size, input logic [2:0] ofs);
    logic [7:0] base;
    case (size)
      SZ_BYTE: base = 8'h01;
      SZ_HALF: base = 8'h03;
      SZ_WORD: base = 8'h0F;
      default: base = 8'hFF;
    endcase
    return base << ofs;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_align_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : lsu_align_unit_if
// Brief    : Execute-stage request/response and data-memory bus bundle for
//            the alignment unit. slave = the unit, master = its environment.
// Revision : 1.0 - initial release
// ============================================================================
interface lsu_align_unit_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  localparam int LANES = DATA_W / 8;

  logic              req_valid;
  logic              req_write;
  logic [1:0]        req_size;
  logic              req_signed;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              stall;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_rdata;
  logic              misalign_err;
  logic              bus_err;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [LANES-1:0]  mem_be;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
    input  mem_ack, mem_rdata,
    output stall, resp_valid, resp_rdata, misalign_err, bus_err,
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );

  modport master (
    output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
    output mem_ack, mem_rdata,
    input  stall, resp_valid, resp_rdata, misalign_err, bus_err,
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );
endinterface
`default_nettype wire

// File: rtl/lsu_align_unit_load_extend.sv
`default_nettype none
// ============================================================================
// Module   : lsu_load_extend
// Brief    : Combinational load-lane select followed by sign/zero extension
//            of the selected field to DATA_W.
// Revision : 1.0 - initial release
// ============================================================================
module lsu_load_extend
  import lsu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int OFS_W  = $clog2(DATA_W / 8)
) (
  input  wire logic [DATA_W-1:0] i_rdata,
  input  wire logic [1:0]        i_size,
  input  wire logic [OFS_W-1:0]  i_ofs,
  input  wire logic              i_sign_ext,
  output logic      [DATA_W-1:0] o_data
);

  logic [DATA_W-1:0] w_shift;
  logic [DATA_W-1:0] w_mask;
  logic              w_top_bit;

  // Right-justify the addressed lane, then keep the field and fill the rest
  // with either zeros or copies of the field's top bit.
  always_comb begin
    w_shift   = i_rdata >> {i_ofs, 3'b000};
    w_mask    = '1;
    w_top_bit = 1'b0;
    case (i_size)
      SZ_BYTE: begin
        w_mask       = '0;
        w_mask[7:0]  = '1;
        w_top_bit    = w_shift[7];
      end
      SZ_HALF: begin
        w_mask       = '0;
        w_mask[15:0] = '1;
        w_top_bit    = w_shift[15];
      end
      SZ_WORD: begin
        w_mask       = '0;
        w_mask[31:0] = '1;
        w_top_bit    = w_shift[31];
      end
      default: begin
        w_mask    = '1;
        w_top_bit = 1'b0;
      end
    endcase
    o_data = (w_shift & w_mask) | ({DATA_W{i_sign_ext & w_top_bit}} & ~w_mask);
  end

endmodule
`default_nettype wire

// File: rtl/lsu_align_unit.sv
`default_nettype none
// ============================================================================
// Module   : lsu_align_unit
// Brief    : Load/store alignment unit. Checks alignment, builds byte enables
//            and lane-replicated store data, runs the memory handshake and
//            stalls the pipeline until the access completes.
//            Optional watchdog: define LSU_TIMEOUT_EN to abort a memory
//            access that is not acknowledged within TIMEOUT_CYCLES.
// Revision : 1.0 - initial release
// ============================================================================
module lsu_align_unit
  import lsu_pkg::*;
#(
  parameter int DATA_W         = 32,
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input wire logic       clk,
  input wire logic       rst_n,
  lsu_align_unit_if.slave bus
);

  localparam int LANES = DATA_W / 8;
  localparam int OFS_W = $clog2(LANES);

  lsu_state_t        r_state;
  lsu_state_t        w_state_nxt;
  logic              w_legal;
  logic              w_accept;
  logic              w_finish;
  logic              w_timeout;
  logic [1:0]        r_size;
  logic              r_signed;
  logic [OFS_W-1:0]  r_ofs;
  logic [DATA_W-1:0] w_wdata_rep;
  logic [DATA_W-1:0] w_load_data;
  logic [OFS_W-1:0]  w_req_ofs;

  assign w_req_ofs = bus.req_addr[OFS_W-1:0];
  assign w_finish  = (r_state == REQ) && (bus.mem_ack || w_timeout);

  // Natural-alignment check; dword only exists on a 64-bit bus.
  always_comb begin
    w_legal = 1'b0;
    case (bus.req_size)
      SZ_BYTE: w_legal = 1'b1;
      SZ_HALF: w_legal = ~bus.req_addr[0];
      SZ_WORD: w_legal = (bus.req_addr[1:0] == 2'b00);
      default: w_legal = (DATA_W == 64) && (bus.req_addr[2:0] == 3'b000);
    endcase
  end

  // Replicate the low (8 << size) bits of store data across every lane.
  always_comb begin
    w_wdata_rep = '0;
    for (int k = 0; k < LANES; k++) begin
      w_wdata_rep[k*8 +: 8] = bus.req_wdata[(k & ((32'sd1 <<< bus.req_size) - 1))*8 +: 8];
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state decode plus the combinational handshake outputs.
  always_comb begin
    w_state_nxt      = r_state;
    w_accept         = 1'b0;
    bus.stall        = 1'b0;
    bus.misalign_err = 1'b0;
    bus.resp_valid   = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.req_valid) begin
          if (w_legal) begin
            bus.stall   = 1'b1;
            w_accept    = 1'b1;
            w_state_nxt = REQ;
          end else begin
            bus.misalign_err = 1'b1;
          end
        end
      end
      REQ: begin
        bus.stall = 1'b1;
        if (w_finish) w_state_nxt = RESP;
      end
      RESP: begin
        bus.resp_valid = 1'b1;
        w_state_nxt    = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Memory-side registers and the captured load result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.mem_req    <= 1'b0;
      bus.mem_we     <= 1'b0;
      bus.mem_addr   <= '0;
      bus.mem_be     <= '0;
      bus.mem_wdata  <= '0;
      bus.resp_rdata <= '0;
      r_size         <= SZ_BYTE;
      r_signed       <= 1'b0;
      r_ofs          <= '0;
    end else if (w_accept) begin
      bus.mem_req   <= 1'b1;
      bus.mem_we    <= bus.req_write;
      bus.mem_addr  <= bus.req_addr & ~ADDR_W'(LANES - 1);
      bus.mem_be    <= LANES'(be_mask(bus.req_size, 3'(w_req_ofs)));
      bus.mem_wdata <= w_wdata_rep;
      r_size        <= bus.req_size;
      r_signed      <= bus.req_signed;
      r_ofs         <= w_req_ofs;
    end else if (w_finish) begin
      bus.mem_req    <= 1'b0;
      bus.mem_we     <= 1'b0;
      bus.resp_rdata <= (bus.mem_ack && !bus.mem_we) ? w_load_data : '0;
    end
  end

  lsu_load_extend #(
    .DATA_W (DATA_W),
    .OFS_W  (OFS_W)
  ) u_load_extend (
    .i_rdata    (bus.mem_rdata),
    .i_size     (r_size),
    .i_ofs      (r_ofs),
    .i_sign_ext (r_signed),
    .o_data     (w_load_data)
  );

`ifdef LSU_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] r_to_cnt;
  logic             r_bus_err;

  assign w_timeout   = (r_state == REQ) && !bus.mem_ack &&
                       (r_to_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign bus.bus_err = r_bus_err;

  // Watchdog: counts unacknowledged REQ cycles; error flag lives for RESP only.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_to_cnt  <= '0;
      r_bus_err <= 1'b0;
    end else begin
      r_bus_err <= w_timeout;
      if (w_accept)                            r_to_cnt <= '0;
      else if (r_state == REQ && !bus.mem_ack) r_to_cnt <= r_to_cnt + 1'b1;
    end
  end
`else
  assign w_timeout   = 1'b0;
  assign bus.bus_err = 1'b0;
`endif

endmodule
`default_nettype wire
